// File: rtl/sc_char_edge_counter.sv
// Counts rising edges of an asynchronous cell-chain output over a programmable
// window of CLK cycles, then publishes the result in parallel and via a serial shifter.
module sc_char_edge_counter #(
    parameter int CNT_W = 16,
    parameter int WIN_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIN_W-1:0] WINDOW,
    input  logic             OSC_IN,
    input  logic             SHIFT,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] COUNT,
    output logic             OVF,
    output logic             SDO
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ARM  = 2'd1;
    localparam logic [1:0] MEAS = 2'd2;
    localparam logic [1:0] FIN  = 2'd3;

    logic [1:0]       state;
    logic             arm_cnt;
    logic             s1, s2, s3;
    logic             edge_det;
    logic [WIN_W-1:0] win_rem;
    logic [CNT_W-1:0] acc, acc_nxt;
    logic             ovf_acc, ovf_nxt;
    logic [CNT_W-1:0] shreg;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= OSC_IN;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_det = s2 & ~s3;

    // Saturating accumulate: a hit at all-ones marks overflow instead of wrapping.
    always_comb begin
        acc_nxt = acc;
        ovf_nxt = ovf_acc;
        if (edge_det) begin
            if (acc != '1) acc_nxt = acc + CNT_W'(1);
            else           ovf_nxt = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            arm_cnt <= 1'b0;
            win_rem <= '0;
            acc     <= '0;
            ovf_acc <= 1'b0;
            COUNT   <= '0;
            OVF     <= 1'b0;
            shreg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        win_rem <= WINDOW;
                        acc     <= '0;
                        ovf_acc <= 1'b0;
                        arm_cnt <= 1'b0;
                        state   <= ARM;
                    end else if (SHIFT) begin
                        shreg <= shreg >> 1;
                    end
                end
                ARM: begin
                    // Two cycles here flush stale synchronizer history before counting.
                    arm_cnt <= ~arm_cnt;
                    if (arm_cnt) begin
                        if (win_rem != '0) begin
                            state <= MEAS;
                        end else begin
                            COUNT <= '0;
                            OVF   <= 1'b0;
                            shreg <= '0;
                            state <= FIN;
                        end
                    end
                end
                MEAS: begin
                    acc     <= acc_nxt;
                    ovf_acc <= ovf_nxt;
                    win_rem <= win_rem - WIN_W'(1);
                    if (win_rem == WIN_W'(1)) begin
                        COUNT <= acc_nxt;
                        OVF   <= ovf_nxt;
                        shreg <= acc_nxt;
                        state <= FIN;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign BUSY = (state != IDLE);
    assign DONE = (state == FIN);
    assign SDO  = shreg[0];

endmodule

// File: tb/tb_sc_char_edge_counter.sv
// Directed + randomized bench for sc_char_edge_counter; counts are predicted from
// the per-cycle OSC_IN sample history, for a 16-bit and a 4-bit counter instance.
module tb_sc_char_edge_counter;

    logic        CLK, RST_N, START, SHIFT, OSC_IN;
    logic [15:0] WINDOW;
    logic        busy_a, done_a, ovf_a, sdo_a;
    logic [15:0] count_a;
    logic        busy_b, done_b, ovf_b, sdo_b;
    logic [3:0]  count_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit osc_hist [0:32767];
    int mode = 0;           // 0: period-4 square, 1: held high, 2: random levels
    int last_a = 0, last_b = 0;

    sc_char_edge_counter #(.CNT_W(16), .WIN_W(16)) dut_a (
        .CLK(CLK), .RST_N(RST_N), .START(START), .WINDOW(WINDOW), .OSC_IN(OSC_IN),
        .SHIFT(SHIFT), .BUSY(busy_a), .DONE(done_a), .COUNT(count_a), .OVF(ovf_a), .SDO(sdo_a)
    );

    sc_char_edge_counter #(.CNT_W(4), .WIN_W(16)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .START(START), .WINDOW(WINDOW), .OSC_IN(OSC_IN),
        .SHIFT(SHIFT), .BUSY(busy_b), .DONE(done_b), .COUNT(count_b), .OVF(ovf_b), .SDO(sdo_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (cyc < 32768) osc_hist[cyc] <= OSC_IN;
        cyc <= cyc + 1;
    end

    initial begin
        logic [1:0] sq;
        int hold;
        sq = 2'd0;
        hold = 0;
        OSC_IN = 1'b0;
        forever begin
            @(negedge CLK);
            case (mode)
                0: begin sq = sq + 2'd1; OSC_IN = sq[1]; end
                1: OSC_IN = 1'b1;
                default: begin
                    if (hold == 0) begin
                        OSC_IN = ~OSC_IN;
                        hold = $urandom_range(1, 4);
                    end else begin
                        hold--;
                    end
                end
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Rising transitions between consecutive CLK samples t..t+w form the measured set.
    function automatic int model_edges(input int t, input int w);
        int n = 0;
        for (int p = t + 1; p <= t + w; p++)
            if (osc_hist[p] && !osc_hist[p-1]) n++;
        return n;
    endfunction

    task automatic run(input int w, input bit dbl_start, input bit shift_busy, input bit start_shift);
        int t, n;
        logic sdo0_a, sdo0_b;
        @(negedge CLK);
        sdo0_a = sdo_a;
        sdo0_b = sdo_b;
        START  = 1'b1;
        WINDOW = 16'(w);
        SHIFT  = start_shift;
        t = cyc;
        for (int k = 1; k <= w + 6; k++) begin
            @(negedge CLK);
            START = dbl_start && (k <= 3);
            SHIFT = shift_busy && (k == 2);
            if (start_shift && k == 1) begin
                chk("start_beats_shift_a", sdo_a, sdo0_a);
                chk("start_beats_shift_b", sdo_b, sdo0_b);
            end
            if (shift_busy && k == 3) begin
                chk("shift_in_busy_a", sdo_a, sdo0_a);
                chk("shift_in_busy_b", sdo_b, sdo0_b);
            end
            chk("busy_a", busy_a, (k <= w + 3));
            chk("busy_b", busy_b, (k <= w + 3));
            chk("done_a", done_a, (k == w + 3));
            chk("done_b", done_b, (k == w + 3));
            if (k == w + 3) begin
                n = model_edges(t, w);
                last_a = (n > 65535) ? 65535 : n;
                last_b = (n > 15) ? 15 : n;
                chk("count_a", count_a, last_a);
                chk("ovf_a", ovf_a, (n > 65535));
                chk("count_b", count_b, last_b);
                chk("ovf_b", ovf_b, (n > 15));
            end
        end
        START = 1'b0;
        SHIFT = 1'b0;
    endtask

    task automatic readout(input int n);
        for (int i = 0; i < n; i++) begin
            chk("sdo_a", sdo_a, (last_a >> i) & 1);
            chk("sdo_b", sdo_b, (last_b >> i) & 1);
            SHIFT = 1'b1;
            @(negedge CLK);
            SHIFT = 1'b0;
        end
        chk("sdo_a_end", sdo_a, (last_a >> n) & 1);
        chk("count_hold_a", count_a, last_a);
        chk("count_hold_b", count_b, last_b);
    endtask

    initial begin
        RST_N  = 1'b0;
        START  = 1'b0;
        SHIFT  = 1'b0;
        WINDOW = 16'd0;
        repeat (2) @(negedge CLK);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_count", count_a, 0);
        chk("rst_ovf", ovf_a, 0);
        chk("rst_sdo", sdo_a, 0);
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);

        // basic count and saturation of the narrow instance
        mode = 0;
        run(100, 0, 0, 0);
        chk("basic_cnt25", count_a, 25);
        chk("sat_cnt15", count_b, 15);
        chk("sat_ovf", ovf_b, 1);

        // short window clears overflow; SHIFT while busy is ignored
        run(20, 0, 1, 0);
        chk("short_cnt5", count_b, 5);
        chk("short_ovf0", ovf_b, 0);

        // static input; START with SHIFT drops the shift
        mode = 1;
        repeat (4) @(negedge CLK);
        run(50, 0, 0, 1);
        chk("static_cnt0", count_a, 0);

        // serial readout of a 25 result
        mode = 0;
        run(100, 0, 0, 0);
        readout(16);

        // zero window with repeated START while busy
        run(0, 1, 0, 0);
        chk("zero_cnt", count_a, 0);
        chk("zero_ovf", ovf_a, 0);

        // randomized oscillator and windows
        mode = 2;
        for (int i = 0; i < 6; i++) begin
            int w;
            w = $urandom_range(1, 200);
            run(w, 0, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
            if (i == 2) readout(8);
        end

        // asynchronous reset mid-measurement
        mode = 0;
        run(100, 0, 0, 0);
        @(negedge CLK);
        START  = 1'b1;
        WINDOW = 16'd100;
        @(negedge CLK);
        START = 1'b0;
        repeat (40) @(negedge CLK);
        chk("pre_rst_busy", busy_a, 1);
        #3 RST_N = 1'b0;
        #1;
        chk("arst_busy_a", busy_a, 0);
        chk("arst_done_a", done_a, 0);
        chk("arst_count_a", count_a, 0);
        chk("arst_ovf_a", ovf_a, 0);
        chk("arst_sdo_a", sdo_a, 0);
        chk("arst_busy_b", busy_b, 0);
        chk("arst_count_b", count_b, 0);
        chk("arst_ovf_b", ovf_b, 0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);
        chk("post_rst_busy", busy_a, 0);
        run(100, 0, 0, 0);
        chk("post_rst_cnt25", count_a, 25);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
